// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the unified memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam int WAIT_MAX_DEFAULT = 255;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the port opposite to the last grant wins.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic  i_if_req,
    input  logic  i_d_req,
    input  port_t i_last_grant,
    output logic  o_valid,
    output port_t o_grant
);

    always_comb begin
        o_valid = i_if_req | i_d_req;
        o_grant = PORT_IF;
        if (i_if_req && i_d_req) begin
            o_grant = (i_last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (i_d_req) begin
            o_grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multiplexes fetch and data requests onto one single-outstanding memory bus
// with waitrequest handshake, one-cycle acks and a sticky timeout flag.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              bus_err,
    output logic              err_src
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    port_t             r_grant;
    port_t             r_last_grant;
    port_t             r_err_src;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_bus_err;

    logic              w_req_valid;
    port_t             w_grant;
    logic              w_done;
    logic              w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_req_valid),
        .o_grant      (w_grant)
    );

    assign w_done    = (r_state == ACCESS) && !mem_waitrequest;
    // The WAIT_MAX-th consecutive wait cycle aborts the transaction.
    assign w_timeout = (r_state == ACCESS) && mem_waitrequest &&
                       (r_wait_cnt == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_req_valid) w_state_next = ACCESS;
            ACCESS:  if (w_done || w_timeout) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bus command comes straight from registers so it is stable for all of ACCESS.
    always_comb begin
        mem_read      = (r_state == ACCESS) && !r_we;
        mem_write     = (r_state == ACCESS) &&  r_we;
        mem_addr      = r_addr;
        mem_writedata = r_wdata;
        if_ack        = (r_state == RESP) && (r_grant == PORT_IF);
        d_ack         = (r_state == RESP) && (r_grant == PORT_D);
        if_rdata      = r_if_rdata;
        d_rdata       = r_d_rdata;
        bus_err       = r_bus_err;
        err_src       = r_err_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= PORT_IF;
            r_last_grant <= PORT_D;
            r_err_src    <= PORT_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_req_valid) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_grant == PORT_D) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_addr  <= if_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (w_done) begin
                        r_wait_cnt <= '0;
                        if (!r_we) begin
                            if (r_grant == PORT_IF) r_if_rdata <= mem_readdata;
                            else                    r_d_rdata  <= mem_readdata;
                        end
                    end else if (w_timeout) begin
                        r_wait_cnt <= '0;
                        r_bus_err  <= 1'b1;
                        r_err_src  <= r_grant;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_wait_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus
// hand sequences for async reset, contention and mid-transaction request drop.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        bus_err;
    logic        err_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_ack          (if_ack),
        .if_rdata        (if_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_ack           (d_ack),
        .d_rdata         (d_rdata),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .bus_err         (bus_err),
        .err_src         (err_src)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic [31:0] bus_rdata;
        int          exp_rd;
        int          exp_wr;
        int          exp_ack_at;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_src;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drives one request and plays the slave; waitrequest is held for nwait strobe cycles.
    task automatic run_txn(input vec_t v, output int rd, output int wr,
                           output int ack_at, output int acks, output int bad);
        int k;
        logic my_ack, other_ack;
        rd = 0; wr = 0; ack_at = 0; acks = 0; bad = 0; k = 0;
        @(negedge clk);
        mem_readdata = v.bus_rdata;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int i = 1; i <= v.nwait + 6; i++) begin
            @(negedge clk);
            if (mem_read)  rd++;
            if (mem_write) wr++;
            if (mem_read && mem_write) bad++;
            if (mem_read || mem_write) begin
                k++;
                if (mem_addr !== v.addr) bad++;
                if (mem_write && mem_writedata !== v.wdata) bad++;
                mem_waitrequest = (k <= v.nwait);
            end else begin
                mem_waitrequest = 1'b0;
            end
            my_ack    = v.is_d ? d_ack  : if_ack;
            other_ack = v.is_d ? if_ack : d_ack;
            if (other_ack) bad++;
            if (my_ack) begin
                acks++;
                if (ack_at == 0) ack_at = i;
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    initial begin
        int rd, wr, ack_at, acks, bad, k, nack;
        int order [4];
        logic [31:0] got_rdata;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h8C22_0004, 1, 0, 2, 32'h8C22_0004, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h1234_5678, 0, 4, 5, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'hCAFE_F00D, 2, 0, 3, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 2, 32'h1111_2222, 3, 0, 4, 32'h1111_2222, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0108, 32'h0000_0055, 0, 32'h9999_9999, 0, 1, 2, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0, 10, 32'hBAD0_BAD0, 4, 0, 5, 32'hCAFE_F00D, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0, 0, 32'hA5A5_A5A5, 1, 0, 2, 32'hA5A5_A5A5, 1'b1, 1'b1};

        // Reset state
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_bus_err", 32'({bus_err, err_src}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        for (int n = 0; n < 7; n++) begin
            run_txn(vecs[n], rd, wr, ack_at, acks, bad);
            got_rdata = vecs[n].is_d ? d_rdata : if_rdata;
            $display("txn %0d port=%0d we=%0d addr=%h waits=%0d rd=%0d wr=%0d ack_at=%0d rdata=%h err=%0d",
                     n, vecs[n].is_d, vecs[n].we, vecs[n].addr, vecs[n].nwait, rd, wr, ack_at,
                     got_rdata, bus_err);
            chk($sformatf("v%0d_rd_cycles", n), 32'(rd), 32'(vecs[n].exp_rd));
            chk($sformatf("v%0d_wr_cycles", n), 32'(wr), 32'(vecs[n].exp_wr));
            chk($sformatf("v%0d_ack_at", n), 32'(ack_at), 32'(vecs[n].exp_ack_at));
            chk($sformatf("v%0d_ack_count", n), 32'(acks), 32'd1);
            chk($sformatf("v%0d_cmd_errors", n), 32'(bad), 32'd0);
            chk($sformatf("v%0d_rdata", n), got_rdata, vecs[n].exp_rdata);
            chk($sformatf("v%0d_bus_err", n), 32'(bus_err), 32'(vecs[n].exp_err));
            if (vecs[n].exp_err) chk($sformatf("v%0d_err_src", n), 32'(err_src), 32'(vecs[n].exp_src));
        end

        // Async reset while mem_read is held by waitrequest
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; mem_waitrequest = 1'b1;
        @(negedge clk);
        chk("arst_pre_read", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_read_drop", 32'(mem_read), 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        if_req = 1'b0; mem_waitrequest = 1'b0; rst_n = 1'b1;
        nack = 0; k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) nack++;
            if (mem_read || mem_write) k++;
        end
        $display("async reset: acks=%0d strobes=%0d bus_err=%0d", nack, k, bus_err);
        chk("arst_no_ack", 32'(nack), 32'd0);
        chk("arst_idle", 32'(k), 32'd0);
        chk("arst_bus_err_post", 32'(bus_err), 32'd0);

        // Both ports held continuously: grants alternate IF, D, IF, D
        @(negedge clk);
        if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0; mem_readdata = 32'h5A5A_0001;
        if_req = 1'b1; d_req = 1'b1;
        nack = 0; bad = 0; k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) k++;
            if (if_ack && d_ack) bad++;
            if ((if_ack || d_ack) && nack < 4) begin
                order[nack] = d_ack ? 1 : 0;
                nack++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        $display("contention: acks=%0d strobes=%0d order=%0d%0d%0d%0d", nack, k,
                 order[0], order[1], order[2], order[3]);
        chk("rr_ack_count", 32'(nack), 32'd4);
        chk("rr_strobes", 32'(k), 32'd4);
        chk("rr_double_ack", 32'(bad), 32'd0);
        for (int j = 0; j < 4; j++) chk($sformatf("rr_grant%0d", j), 32'(order[j]), 32'(j % 2));

        // Load request dropped mid-ACCESS still completes exactly once
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_readdata = 32'h0000_0077;
        nack = 0; k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (d_ack) nack++;
            if (mem_read || mem_write) begin
                k++;
                mem_waitrequest = (k <= 2);
                d_req = 1'b0;
            end else begin
                mem_waitrequest = 1'b0;
            end
        end
        $display("drop mid-access: acks=%0d strobes=%0d d_rdata=%h", nack, k, d_rdata);
        chk("drop_ack_count", 32'(nack), 32'd1);
        chk("drop_strobes", 32'(k), 32'd3);
        chk("drop_rdata", d_rdata, 32'h0000_0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one unified memory bus between the instruction-fetch port (driven from the PC) and the data port (load/store, qualified by MemRead/MemWrite). Converts the CPU's split fetch/data requests into single-outstanding bus transactions with a wait-request handshake. Returns one-cycle acknowledges plus registered read data, and reports a sticky timeout error. Sits between controlpath/datapath and the memory model; the CPU stalls while either of its requests is unacknowledged.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width of both ports and the bus
WAIT_MAX, 255, maximum consecutive waitrequest cycles before a transaction is aborted with error

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetched word, valid with if_ack, held until next fetch ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid with d_ack, held until next data ack
mem_addr  out  ADDR_W  bus address
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_writedata  out  DATA_W  bus write data
mem_waitrequest  in  1  slave not ready; the command must be held
mem_readdata  in  DATA_W  bus read data, valid when the strobe is high and waitrequest is low
bus_err  out  1  sticky timeout flag
err_src  out  1  port that timed out (0 = fetch, 1 = data); valid while bus_err = 1

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant one port and latch its addr/we/wdata into internal registers; next state ACCESS.
  - Only one port requesting: grant that port.
  - Both requesting: round-robin, granting the port opposite to last_grant. last_grant updates on each grant.
- ACCESS:
  - mem_read/mem_write and mem_addr/mem_writedata are driven from registers only; they are stable for the whole state.
  - Fetch grant always performs a read.
  - Completes in the first cycle with mem_waitrequest = 0: capture mem_readdata into the granted port's rdata register (loads and fetches only); next state RESP.
  - Wait counter counts consecutive cycles with waitrequest = 1. On reaching WAIT_MAX: set bus_err, set err_src to the granted port, go to RESP without updating rdata.
- RESP:
  - Pulse the granted port's ack for exactly one cycle; strobes are low.
  - Next state IDLE.
  - Requests sampled in RESP are ignored; the requester drops or changes its request during the ack cycle.
- Latency, zero wait: request seen at edge N; strobe high in cycle N+1; ack in cycle N+2; the next grant is possible at edge N+3. Every extra waitrequest cycle adds one cycle.
- One transaction outstanding at a time; never more than one strobe high; strobes are low in IDLE and RESP.
- A request deasserted mid-ACCESS does not abort the transaction; it completes and the ack is still issued.
- bus_err clears only on reset; later transactions proceed normally.
- Reset, asynchronous and taking effect mid-transaction as well:
  - All strobes and acks go to 0 immediately.
  - State = IDLE; counters = 0; rdata registers = 0; bus_err = 0; err_src = 0.
  - last_grant = data, so fetch wins the first contention.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum arb_state_t {IDLE, ACCESS, RESP};
  - the port-id enum port_t {PORT_IF = 0, PORT_D = 1};
  - the default WAIT_MAX constant.
- One sub-module, rr_arb2: combinational two-way round-robin grant from (if_req, d_req, last_grant) to granted port_t. The FSM, registers and wait counter stay in the top module.

Test Plan:
- Single fetch, if_addr = 0x00000010, waitrequest = 0, readdata = 0x8C220004 -> mem_read high for exactly 1 cycle at addr 0x10; if_ack pulses 2 cycles after the request; if_rdata = 0x8C220004.
- Store: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, waitrequest high for 3 cycles -> mem_write held 4 cycles with stable addr/data; d_ack 1 cycle after waitrequest drops; d_rdata unchanged.
- if_req and d_req asserted together after reset -> fetch granted first, then data. Repeat both held continuously -> grants alternate IF, D, IF, D.
- Load with waitrequest stuck high, WAIT_MAX = 4 -> abort after 4 wait cycles; d_ack pulses; bus_err = 1; err_src = 1. A following fetch completes normally and bus_err stays 1.
- rst_n pulsed low during ACCESS with mem_read high -> mem_read drops asynchronously; no ack; after release, state IDLE and bus_err = 0.
- d_req dropped during ACCESS -> transaction completes; d_ack pulses once; no second bus cycle is issued.
